// File: rtl/fp_conv_pkg.sv
// Shared constants and elaboration-time helpers for the int-to-float conversion scheduler.
package fp_conv_pkg;

    localparam int ConvLatency = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic int out_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int num_req);
        return (clog2(num_req) > 1) ? clog2(num_req) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fp_conv_scheduler_if.sv
// Requester-side and result-side handshake bundle of the conversion scheduler.
interface fp_conv_scheduler_if #(
    parameter int NumReq   = 4,
    parameter int InWidth  = 32,
    parameter int OutWidth = 32,
    parameter int IdWidth  = 2
);
    logic [NumReq*InWidth-1:0] ReqData_i;
    logic [NumReq-1:0]         ReqVal_i;
    logic [NumReq-1:0]         ReqRdy_o;
    logic [OutWidth-1:0]       OutData_o;
    logic [IdWidth-1:0]        OutId_o;
    logic                      OutVal_o;
    logic                      OutRdy_i;
    logic                      Busy_o;

    modport master (
        output ReqData_i, ReqVal_i, OutRdy_i,
        input  ReqRdy_o, OutData_o, OutId_o, OutVal_o, Busy_o
    );

    modport slave (
        input  ReqData_i, ReqVal_i, OutRdy_i,
        output ReqRdy_o, OutData_o, OutId_o, OutVal_o, Busy_o
    );
endinterface

// File: rtl/MyIntToFp.sv
// Two-stage signed integer to float converter: truncating, zero maps to +0.0, no stall input.
module MyIntToFp
    import fp_conv_pkg::*;
#(
    parameter int InWidth  = 32,
    parameter int ExpWidth = 8,
    parameter int ManWidth = 23,
    parameter int ExpConst = 127
) (
    input  logic                      Clk_i,
    input  logic                      Rst_i,
    input  logic [InWidth-1:0]        InData_i,
    input  logic                      InDataVal_i,
    output logic [ExpWidth+ManWidth:0] OutData_o,
    output logic                      OutDataVal_o
);
    localparam int PosWidth = clog2(InWidth);

    logic                          sign_q, sign_d;
    logic [InWidth-1:0]            mag_q, mag_d;
    logic                          val1_q, val1_d;
    logic [ExpWidth+ManWidth:0]    res_q, res_d;
    logic                          val2_q, val2_d;
    logic [PosWidth-1:0]           pos;
    logic [InWidth-1:0]            norm;
    logic [InWidth+ManWidth-1:0]   ext;
    logic [ManWidth-1:0]           man;
    logic [ExpWidth-1:0]           expo;

    always_comb begin
        sign_d = InData_i[InWidth-1];
        mag_d  = InData_i[InWidth-1] ? -InData_i : InData_i;
        val1_d = InDataVal_i;
    end

    // Normalise so the leading one sits at the MSB; the bits below it are the truncated mantissa.
    always_comb begin
        pos = '0;
        for (int i = 0; i < InWidth; i++) begin
            if (mag_q[i]) begin
                pos = PosWidth'(i);
            end
        end
        norm   = mag_q << (PosWidth'(InWidth - 1) - pos);
        ext    = {norm, {ManWidth{1'b0}}};
        man    = ext[InWidth+ManWidth-2 -: ManWidth];
        expo   = ExpWidth'(ExpConst) + ExpWidth'(pos);
        res_d  = (mag_q != '0) ? {sign_q, expo, man} : '0;
        val2_d = val1_q;
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            val1_q <= 1'b0;
            res_q  <= '0;
            val2_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
            mag_q  <= mag_d;
            val1_q <= val1_d;
            res_q  <= res_d;
            val2_q <= val2_d;
        end
    end

    assign OutData_o    = res_q;
    assign OutDataVal_o = val2_q;
endmodule

// File: rtl/fp_rr_arbiter.sv
// Round-robin arbiter with combinational grant; the pointer advances only when a grant is issued.
module fp_rr_arbiter
    import fp_conv_pkg::*;
#(
    parameter int NumReq  = 4,
    parameter int IdWidth = id_width(NumReq)
) (
    input  logic               Clk_i,
    input  logic               Rst_i,
    input  logic [NumReq-1:0]  Req_i,
    input  logic               En_i,
    output logic [NumReq-1:0]  Gnt_o,
    output logic [IdWidth-1:0] GntIdx_o,
    output logic               GntVal_o
);
    logic [IdWidth-1:0] ptr_q, ptr_d;
    logic [IdWidth-1:0] cand;
    logic               found;

    // Search starts one past the last winner and wraps.
    always_comb begin
        Gnt_o    = '0;
        GntIdx_o = '0;
        found    = 1'b0;
        cand     = '0;
        for (int off = 1; off <= NumReq; off++) begin
            cand = IdWidth'((int'(ptr_q) + off) % NumReq);
            if (!found && En_i && Req_i[cand]) begin
                found       = 1'b1;
                Gnt_o[cand] = 1'b1;
                GntIdx_o    = cand;
            end
        end
        GntVal_o = found;
        ptr_d    = found ? GntIdx_o : ptr_q;
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            ptr_q <= IdWidth'(NumReq - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/fp_conv_scheduler.sv
// Shares one int-to-float converter among NumReq requesters; results leave through a
// credit-protected FIFO tagged with the originating requester index.
module fp_conv_scheduler
    import fp_conv_pkg::*;
#(
    parameter int NumReq   = 4,
    parameter int InWidth  = 32,
    parameter int ExpWidth = 8,
    parameter int ManWidth = 23,
    parameter int OutDepth = 4
) (
    input logic               Clk_i,
    input logic               Rst_i,
    fp_conv_scheduler_if.slave bus
);
    localparam int OutWidth  = out_width(ExpWidth, ManWidth);
    localparam int IdWidth   = id_width(NumReq);
    localparam int CntWidth  = cnt_width(OutDepth);
    localparam int AddrWidth = clog2(OutDepth);
    localparam int WordWidth = IdWidth + OutWidth;
    localparam int ExpConst  = (1 << (ExpWidth - 1)) - 1;
    localparam logic [CntWidth:0]  DepthLimit = (CntWidth + 1)'(OutDepth);
    localparam logic [AddrWidth:0] MemFull    = (AddrWidth + 1)'(OutDepth);

    logic [NumReq-1:0]    gnt;
    logic [IdWidth-1:0]   gnt_idx;
    logic                 issue;
    logic                 credit_ok;
    logic [InWidth-1:0]   conv_in;
    logic [OutWidth-1:0]  conv_out;
    logic                 conv_val;

    logic [CntWidth-1:0]  inflight_q, inflight_d;
    logic [CntWidth-1:0]  occ_q, occ_d;
    logic [IdWidth-1:0]   tag_q [ConvLatency];
    logic [IdWidth-1:0]   tag_d [ConvLatency];
    logic [ConvLatency-1:0] tag_val_q, tag_val_d;

    logic [WordWidth-1:0] fifo_mem [OutDepth];
    logic [AddrWidth:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AddrWidth:0]   mem_cnt;
    logic [WordWidth-1:0] out_word_q, out_word_d;
    logic                 out_val_q, out_val_d;
    logic                 pop, load;

    // Every accepted word owns one slot until popped, so FIFO overflow is impossible.
    assign credit_ok = ({1'b0, occ_q} + {1'b0, inflight_q}) < DepthLimit;

    fp_rr_arbiter #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) u_arb (
        .Clk_i    (Clk_i),
        .Rst_i    (Rst_i),
        .Req_i    (bus.ReqVal_i),
        .En_i     (credit_ok && !Rst_i),
        .Gnt_o    (gnt),
        .GntIdx_o (gnt_idx),
        .GntVal_o (issue)
    );

    assign bus.ReqRdy_o = gnt;
    assign conv_in      = bus.ReqData_i[int'(gnt_idx)*InWidth +: InWidth];

    MyIntToFp #(
        .InWidth  (InWidth),
        .ExpWidth (ExpWidth),
        .ManWidth (ManWidth),
        .ExpConst (ExpConst)
    ) u_conv (
        .Clk_i        (Clk_i),
        .Rst_i        (Rst_i),
        .InData_i     (conv_in),
        .InDataVal_i  (issue),
        .OutData_o    (conv_out),
        .OutDataVal_o (conv_val)
    );

    assign mem_cnt = wr_ptr_q - rd_ptr_q;
    assign pop     = out_val_q && bus.OutRdy_i;
    assign load    = (mem_cnt != '0) && (!out_val_q || pop);

    always_comb begin
        tag_d[0]     = gnt_idx;
        tag_val_d[0] = issue;
        for (int i = 1; i < ConvLatency; i++) begin
            tag_d[i]     = tag_q[i-1];
            tag_val_d[i] = tag_val_q[i-1];
        end
        inflight_d = inflight_q + CntWidth'(issue) - CntWidth'(conv_val);
        occ_d      = occ_q + CntWidth'(conv_val) - CntWidth'(pop);
        wr_ptr_d   = wr_ptr_q + (AddrWidth + 1)'(conv_val);
        rd_ptr_d   = rd_ptr_q + (AddrWidth + 1)'(load);
        out_word_d = load ? fifo_mem[rd_ptr_q[AddrWidth-1:0]] : out_word_q;
        out_val_d  = load ? 1'b1 : (pop ? 1'b0 : out_val_q);
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            tag_q      <= '{default: '0};
            tag_val_q  <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_word_q <= '0;
            out_val_q  <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            tag_val_q  <= tag_val_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_word_q <= out_word_d;
            out_val_q  <= out_val_d;
        end
    end

    // Result storage carries no reset so it maps onto block RAM.
    always_ff @(posedge Clk_i) begin
        if (conv_val) begin
            fifo_mem[wr_ptr_q[AddrWidth-1:0]] <= {tag_q[ConvLatency-1], conv_out};
        end
    end

    assign bus.OutVal_o  = out_val_q;
    assign bus.OutData_o = out_word_q[OutWidth-1:0];
    assign bus.OutId_o   = out_word_q[WordWidth-1 -: IdWidth];
    assign bus.Busy_o    = (inflight_q != '0) || (occ_q != '0);

    a_no_write_when_full: assert property (@(posedge Clk_i) disable iff (Rst_i)
        !(conv_val && (mem_cnt == MemFull)));
    a_tag_aligned: assert property (@(posedge Clk_i) disable iff (Rst_i)
        conv_val == tag_val_q[ConvLatency-1]);
endmodule
